// File: rtl/shift_sched_pkg.sv
// Shared definitions for the barrel-rotator sequencer: op codes, FSM states,
// arbitration defaults and the rotate-amount helper.
package shift_sched_pkg;

  typedef enum logic [1:0] {
    OP_ROT  = 2'b00,
    OP_LDB  = 2'b01,
    OP_DPB  = 2'b10,
    OP_MASK = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PASS1 = 2'b01,
    ST_PASS2 = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  localparam int STARVE_LIMIT_DEF = 4;

  // LDB brings the field down to bit 0 by rotating left by (-pos) mod 32.
  function automatic logic [4:0] neg_amt(input logic [4:0] pos);
    return 5'd0 - pos;
  endfunction

endpackage

// File: rtl/shift_sched_field_mask.sv
// Low-order field mask generator: width holds (field bits - 1), so 31 means all ones.
module field_mask (
  input  logic [4:0]  width,
  output logic [31:0] mask
);

  // A right shift of all-ones avoids the 1<<32 overflow of the (1<<(w+1))-1 form.
  assign mask = 32'hFFFF_FFFF >> (5'd31 - width);

endmodule

// File: rtl/shift_sched.sv
// Two-port sequencer/arbiter for the shared 32-bit barrel rotator: grants one field
// operation at a time, drives one or two rotator passes and returns the merged result.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_pos,
  input  logic [4:0]  req0_width,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_pos,
  input  logic [4:0]  req1_width,
  output logic [31:0] rot_m,
  output logic [4:0]  rot_amt,
  input  logic [31:0] rot_r,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_e          state_r;
  state_e          state_s;
  logic [SW-1:0]   starve_r;
  op_e             op_r;
  logic [31:0]     b_r;
  logic [31:0]     r1_r;
  logic [4:0]      pos_r;
  logic [4:0]      width_r;
  logic            id_r;

  logic            grant0_s;
  logic            grant1_s;
  logic            accept_s;
  logic [1:0]      sel_op_s;
  logic [31:0]     sel_a_s;
  logic [31:0]     sel_b_s;
  logic [4:0]      sel_pos_s;
  logic [4:0]      sel_width_s;
  logic [31:0]     sel_mask_s;
  logic [31:0]     lat_mask_s;
  logic [31:0]     acc_m_s;
  logic [4:0]      acc_amt_s;
  logic [31:0]     pass1_res_s;
  logic [31:0]     merge_s;

  field_mask u_sel_mask (
    .width (sel_width_s),
    .mask  (sel_mask_s)
  );

  field_mask u_lat_mask (
    .width (width_r),
    .mask  (lat_mask_s)
  );

  // Starvation-limited fixed priority; grants only exist in IDLE and outside reset.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_r == ST_IDLE) && !reset) begin
      if ((starve_r == STARVE_MAX) && req1_valid) begin
        grant1_s = 1'b1;
      end else if (req0_valid) begin
        grant0_s = 1'b1;
      end else if (req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
      end
    end else begin
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign accept_s   = grant0_s | grant1_s;

  // Operand mux toward the granted port.
  always_comb begin
    sel_op_s    = req0_op;
    sel_a_s     = req0_a;
    sel_b_s     = req0_b;
    sel_pos_s   = req0_pos;
    sel_width_s = req0_width;
    if (grant1_s) begin
      sel_op_s    = req1_op;
      sel_a_s     = req1_a;
      sel_b_s     = req1_b;
      sel_pos_s   = req1_pos;
      sel_width_s = req1_width;
    end else begin
      sel_op_s    = req0_op;
    end
  end

  // First-pass rotator setup loaded at the accept edge.
  always_comb begin
    acc_m_s   = sel_a_s;
    acc_amt_s = sel_pos_s;
    case (op_e'(sel_op_s))
      OP_MASK: begin
        acc_m_s   = sel_mask_s;
        acc_amt_s = sel_pos_s;
      end
      OP_LDB: begin
        acc_m_s   = sel_a_s;
        acc_amt_s = neg_amt(sel_pos_s);
      end
      default: begin
        acc_m_s   = sel_a_s;
        acc_amt_s = sel_pos_s;
      end
    endcase
  end

  // Result forming: LDB trims to the field; DPB merges pass 1 into b under the rotated mask.
  always_comb begin
    pass1_res_s = rot_r;
    if (op_r == OP_LDB) begin
      pass1_res_s = rot_r & lat_mask_s;
    end else begin
      pass1_res_s = rot_r;
    end
    merge_s = (b_r & ~rot_r) | (r1_r & rot_r);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_PASS1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PASS1: begin
        if (op_r == OP_DPB) begin
          state_s = ST_PASS2;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_PASS2: state_s = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and starvation counter (only evaluated in IDLE).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      starve_r <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_IDLE) begin
        if (!req1_valid || grant1_s) begin
          starve_r <= '0;
        end else if (grant0_s && (starve_r != STARVE_MAX)) begin
          starve_r <= starve_r + SW'(1);
        end else begin
          starve_r <= starve_r;
        end
      end else begin
        starve_r <= starve_r;
      end
    end
  end

  // Datapath: operand latches, rotator drive and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r       <= OP_ROT;
      b_r        <= 32'd0;
      r1_r       <= 32'd0;
      pos_r      <= 5'd0;
      width_r    <= 5'd0;
      id_r       <= 1'b0;
      rot_m      <= 32'd0;
      rot_amt    <= 5'd0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r    <= op_e'(sel_op_s);
            b_r     <= sel_b_s;
            pos_r   <= sel_pos_s;
            width_r <= sel_width_s;
            id_r    <= grant1_s;
            rot_m   <= acc_m_s;
            rot_amt <= acc_amt_s;
          end
        end
        ST_PASS1: begin
          if (op_r == OP_DPB) begin
            r1_r    <= rot_r;
            rot_m   <= lat_mask_s;
            rot_amt <= pos_r;
          end else begin
            resp_data  <= pass1_res_s;
            resp_id    <= id_r;
            resp_valid <= 1'b1;
          end
        end
        ST_PASS2: begin
          resp_data  <= merge_s;
          resp_id    <= id_r;
          resp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: resp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Scoreboard bench for shift_sched: directed field-op cases, arbitration sequence,
// backpressure and mid-operation reset, then randomized two-port traffic.
module tb_shift_sched;
  import shift_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vld [2];
  logic [1:0]  op  [2];
  logic [31:0] a   [2];
  logic [31:0] b   [2];
  logic [4:0]  pos [2];
  logic [4:0]  wid [2];
  logic        rdy0, rdy1;
  logic [31:0] rot_m, rot_r;
  logic [4:0]  rot_amt;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_data;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          grants[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cyc = -100;
  bit          acc [2];
  bit          en  [2];
  int          rate [2];
  int          rr_rate = 100;
  bit          hold = 1'b0;
  bit          seen = 1'b0;
  bit          chk_rot = 1'b0;
  logic [31:0] exp_m;
  logic [4:0]  exp_amt;
  logic [31:0] last_data;
  logic        last_id;

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    if (k == 0) return x;
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] mask_of(input int w);
    logic [63:0] t;
    t = (64'd1 << (w + 1)) - 64'd1;
    return t[31:0];
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] av,
                                             input logic [31:0] bv, input int p, input int w);
    logic [31:0] m;
    case (o)
      2'b00: return rotl(av, p);
      2'b01: return rotl(av, (32 - p) % 32) & mask_of(w);
      2'b11: return rotl(mask_of(w), p);
      default: begin
        m = rotl(mask_of(w), p);
        return (bv & ~m) | (rotl(av, p) & m);
      end
    endcase
  endfunction

  assign rot_r = rotl(rot_m, int'(rot_amt));

  shift_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (vld[0]),
    .req0_ready (rdy0),
    .req0_op    (op[0]),
    .req0_a     (a[0]),
    .req0_b     (b[0]),
    .req0_pos   (pos[0]),
    .req0_width (wid[0]),
    .req1_valid (vld[1]),
    .req1_ready (rdy1),
    .req1_op    (op[1]),
    .req1_a     (a[1]),
    .req1_b     (b[1]),
    .req1_pos   (pos[1]),
    .req1_width (wid[1]),
    .rot_m      (rot_m),
    .rot_amt    (rot_amt),
    .rot_r      (rot_r),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic rand_req(input int p);
    op[p]  = 2'($urandom_range(0, 3));
    a[p]   = $urandom;
    b[p]   = $urandom;
    pos[p] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    wid[p] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
    vld[p] = 1'b1;
  endtask

  // Driver: retires accepted requests, optionally loads random ones, drives resp_ready.
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) begin
        acc[p] = 1'b0;
        vld[p] = 1'b0;
      end
      if (!vld[p] && en[p] && ($urandom_range(0, 99) < rate[p])) rand_req(p);
    end
    resp_ready = hold ? 1'b0 : ($urandom_range(0, 99) < rr_rate);
  end

  // Monitor: records accepts into the scoreboard and checks every response cycle.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("ready_in_reset", 32'({rdy0, rdy1}), 32'd0);
      exp_q.delete();
      seen    = 1'b0;
      chk_rot = 1'b0;
    end else begin
      chk("both_ready", 32'(rdy0 & rdy1), 32'd0);
      if (chk_rot && (cyc == acc_cyc + 1)) begin
        chk("pass1_rot_amt", 32'(rot_amt), 32'(exp_amt));
        chk("pass1_rot_m", rot_m, exp_m);
        chk_rot = 1'b0;
      end
      if (resp_valid) begin
        chk("ready_during_resp", 32'(rdy0 | rdy1), 32'd0);
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          if (!seen) chk("resp_latency", 32'(cyc - acc_cyc), 32'(exp_q[0].lat));
          seen = 1'b1;
          chk("resp_id", 32'(resp_id), 32'(exp_q[0].id));
          chk("resp_data", resp_data, exp_q[0].data);
          if (resp_ready) begin
            last_data = resp_data;
            last_id   = resp_id;
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (vld[p] && ((p == 0) ? rdy0 : rdy1)) begin
          exp_t e;
          e.id   = (p == 1);
          e.data = ref_result(op[p], a[p], b[p], int'(pos[p]), int'(wid[p]));
          e.lat  = (op[p] == 2'b10) ? 3 : 2;
          exp_q.push_back(e);
          acc_cyc = cyc;
          acc[p]  = 1'b1;
          grants.push_back(p);
          exp_amt = (op[p] == 2'b01) ? 5'((32 - int'(pos[p])) % 32) : pos[p];
          exp_m   = (op[p] == 2'b11) ? mask_of(int'(wid[p])) : a[p];
          chk_rot = 1'b1;
        end
      end
    end
  end

  task automatic issue(input int p, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [4:0] ps, input logic [4:0] w);
    int n;
    @(posedge clk); #2;
    op[p] = o; a[p] = av; b[p] = bv; pos[p] = ps; wid[p] = w; vld[p] = 1'b1;
    n = 0;
    while (vld[p] && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("accept_timeout", 32'(vld[p]), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || resp_valid || vld[0] || vld[1]) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_g[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int p = 0; p < 2; p++) begin
      vld[p] = 1'b0; op[p] = 2'b00; a[p] = 32'd0; b[p] = 32'd0;
      pos[p] = 5'd0; wid[p] = 5'd0; en[p] = 1'b0; rate[p] = 0; acc[p] = 1'b0;
    end
    resp_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_rot_m", rot_m, 32'd0);
    chk("rst_rot_amt", 32'(rot_amt), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Arbitration: both ports continuously valid from a cleared starvation count.
    grants.delete();
    en[0] = 1'b1; en[1] = 1'b1; rate[0] = 100; rate[1] = 100;
    n = 0;
    while (grants.size() < 10 && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    en[0] = 1'b0; en[1] = 1'b0;
    chk("grant_count_timeout", 32'(grants.size() >= 10), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i < grants.size()) chk($sformatf("grant_seq[%0d]", i), 32'(grants[i]), 32'(exp_g[i]));
    end
    drain();

    issue(0, 2'b00, 32'h8000_0001, 32'd0, 5'd1, 5'd0);
    drain();
    chk("rot_data", last_data, 32'h0000_0003);
    chk("rot_id", 32'(last_id), 32'd0);

    issue(1, 2'b01, 32'h1234_5678, 32'd0, 5'd8, 5'd7);
    drain();
    chk("ldb_data", last_data, 32'h0000_0056);
    chk("ldb_id", 32'(last_id), 32'd1);

    issue(0, 2'b10, 32'h0000_00AB, 32'hFFFF_FFFF, 5'd4, 5'd7);
    drain();
    chk("dpb_data", last_data, 32'hFFFF_FABF);

    issue(1, 2'b11, 32'd0, 32'd0, 5'd5, 5'd31);
    drain();
    chk("mask_full", last_data, 32'hFFFF_FFFF);

    issue(0, 2'b00, 32'hDEAD_BEEF, 32'd0, 5'd0, 5'd3);
    drain();
    chk("rot_pos0", last_data, 32'hDEAD_BEEF);

    // Backpressure: result held while a port-1 request waits.
    hold = 1'b1;
    issue(0, 2'b01, 32'hCAFE_BABE, 32'd0, 5'd12, 5'd15);
    @(posedge clk); #2;
    op[1] = 2'b00; a[1] = 32'h0000_0010; b[1] = 32'd0; pos[1] = 5'd4; wid[1] = 5'd0; vld[1] = 1'b1;
    n = 0;
    while (!resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_data", resp_data, 32'h0000_AFEB);
      chk("hold_id", 32'(resp_id), 32'd0);
      chk("hold_no_accept", 32'(vld[1]), 32'd1);
    end
    hold = 1'b0;
    drain();
    chk("after_hold_rot", last_data, 32'h0000_0100);

    // Reset in PASS2 of a DPB discards the operation.
    issue(0, 2'b10, 32'h1234_5678, 32'h0F0F_0F0F, 5'd9, 5'd11);
    @(posedge clk); #2;
    chk("in_pass2", 32'(dut.state_r), 32'(ST_PASS2));
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_state", 32'(dut.state_r), 32'(ST_IDLE));
    chk("rst_mid_rot_m", rot_m, 32'd0);
    chk("rst_mid_rot_amt", 32'(rot_amt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    issue(1, 2'b00, 32'h0000_00F0, 32'd0, 5'd28, 5'd0);
    drain();
    chk("post_rst_rot", last_data, 32'h0000_000F);

    // Randomized two-port traffic with random backpressure.
    en[0] = 1'b1; en[1] = 1'b1; rate[0] = 35; rate[1] = 30; rr_rate = 60;
    repeat (3000) @(posedge clk);
    #2;
    en[0] = 1'b0; en[1] = 1'b0; rr_rate = 100;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
